xy2_point_feeder: RTL

Upstream point scheduler for the XY2-100 galvo serial transmitter. Accepts 16-bit position words over a valid/ready stream and buffers them in a small FIFO. Launches one transmitter frame per word: it drives the transmitter's 16-bit data input and one-cycle start pulse, and paces frames to a programmable minimum period. It tracks the transmitter's done flag through a two-phase handshake, so a stale done level is never mistaken for completion.

---
 rtl/xy2_point_feeder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/xy2_point_feeder.sv
// xy2_point_feeder: point scheduler in front of the XY2-100 galvo transmitter.
// It buffers 16-bit position words in a FIFO and launches one transmitter
// frame per word, no more often than once every FRAME_CYCLES clocks.
// Completion is tracked through the transmitter's done flag: done must fall
// and then rise again before a frame counts as complete.
//
// Optional feature (compile-time macro XY2_HOLD_LAST_EN):
//   defined   - when the FIFO runs dry, the last word is re-sent so the
//               galvo frame stream stays continuous (Underrun still sets).
//   undefined - when the FIFO runs dry, no frame is launched; Underrun sets.
//
// Ports:
//   Clk, Rst_n             clock; asynchronous active-low reset
//   Enable                 1 = frames may be launched; 0 = finish current, hold
//   Pt_Data/Valid/Ready    input point stream (push on Pt_Valid && Pt_Ready)
//   Send_Data, Send_Start  word and one-cycle launch pulse to the transmitter
//   Send_Done              transmitter idle flag
//   Fifo_Level             number of buffered words
//   Frame_Tick             one-cycle pulse when a frame completes
//   Underrun, Err_Timeout  sticky status flags; Clr_Err clears both
module xy2_point_feeder #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned FRAME_CYCLES = 400,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Enable,
  input  logic [15:0]     Pt_Data,
  input  logic            Pt_Valid,
  output logic            Pt_Ready,
  output logic [15:0]     Send_Data,
  output logic            Send_Start,
  input  logic            Send_Done,
  output logic [ADDR_W:0] Fifo_Level,
  output logic            Frame_Tick,
  output logic            Underrun,
  output logic            Err_Timeout,
  input  logic            Clr_Err
);

  localparam int unsigned     PC_W     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [PC_W-1:0] PC_MAX   = PC_W'(FRAME_CYCLES - 1);
  localparam int unsigned     BC_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BC_MAX   = BC_W'(BUSY_TIMEOUT - 1);
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic [PC_W-1:0]   pc;
  logic [BC_W-1:0]   bc;
  logic              have_last;

  logic push, pop, pacer_ok, fifo_empty, launch_ok;
  logic start_nxt, tick_nxt, underrun_set, timeout_set;

  assign push       = Pt_Valid && Pt_Ready;
  assign pacer_ok   = (pc == PC_MAX);
  assign fifo_empty = (Fifo_Level == '0);
  assign launch_ok  = Enable && pacer_ok && Send_Done;

  // Next-state and control decode.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    start_nxt    = 1'b0;
    tick_nxt     = 1'b0;
    underrun_set = 1'b0;
    timeout_set  = 1'b0;
    case (state)
      IDLE: begin
        if (launch_ok) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            start_nxt = 1'b1;
            state_nxt = WAIT_BUSY;
          end else if (have_last) begin
            underrun_set = 1'b1;
`ifdef XY2_HOLD_LAST_EN
            // Send_Data is left untouched, so the last word goes out again.
            start_nxt = 1'b1;
            state_nxt = WAIT_BUSY;
`endif
          end
        end
      end
      WAIT_BUSY: begin
        // Done is still high from the previous frame for a cycle after the
        // start; only its fall proves the transmitter took the frame.
        if (!Send_Done) begin
          state_nxt = WAIT_DONE;
        end else if (bc == BC_MAX) begin
          timeout_set = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (Send_Done) begin
          tick_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = Fifo_Level;
    if (push && !pop) begin
      level_nxt = Fifo_Level + (ADDR_W + 1)'(1);
    end else if (!push && pop) begin
      level_nxt = Fifo_Level - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Storage carries no reset; level and pointers define what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= Pt_Data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Fifo_Level  <= '0;
      Pt_Ready    <= 1'b0;
      Send_Data   <= '0;
      Send_Start  <= 1'b0;
      Frame_Tick  <= 1'b0;
      have_last   <= 1'b0;
      pc          <= PC_MAX;
      bc          <= '0;
      Underrun    <= 1'b0;
      Err_Timeout <= 1'b0;
    end else begin
      Send_Start <= start_nxt;
      Frame_Tick <= tick_nxt;
      Fifo_Level <= level_nxt;
      // Taken from the next level so a full FIFO never advertises space.
      Pt_Ready   <= (level_nxt != LVL_FULL);

      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        Send_Data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        have_last <= 1'b1;
      end

      if (start_nxt) begin
        pc <= '0;
      end else if (pc != PC_MAX) begin
        pc <= pc + PC_W'(1);
      end

      if (start_nxt) begin
        bc <= '0;
      end else if (state == WAIT_BUSY && bc != BC_MAX) begin
        bc <= bc + BC_W'(1);
      end

      if (underrun_set) begin
        Underrun <= 1'b1;
      end else if (Clr_Err) begin
        Underrun <= 1'b0;
      end

      if (timeout_set) begin
        Err_Timeout <= 1'b1;
      end else if (Clr_Err) begin
        Err_Timeout <= 1'b0;
      end
    end
  end

endmodule
